fan_soft_start: RTL and testbench

Fan motor soft-start / soft-stop stage placed between the fan duty selection logic and the fan motor PWM generator (pwm_100 at 100-step resolution). It replaces the instantaneous on/off duty switching driven by ultrasonic presence and timer expiry with a rate-limited duty ramp. It also adds a presence hold-off so that brief loss of presence does not stop the fan. Output duty_out feeds the PWM duty input directly.

---
 rtl/fan_soft_start_if.sv | 28 ++
 rtl/fan_soft_start.sv | 127 ++++++++++++
 tb/tb_fan_soft_start.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fan_soft_start_if.sv
// Duty request / ramped duty bundle between fan duty selection, the soft-start
// stage and the PWM generator.
interface fan_soft_start_if;
    logic [6:0] target_duty;
    logic       present;
    logic       enable;
    logic [6:0] duty_out;
    logic       fan_on;
    logic       hold_active;

    modport master (
        output target_duty,
        output present,
        output enable,
        input  duty_out,
        input  fan_on,
        input  hold_active
    );

    modport slave (
        input  target_duty,
        input  present,
        input  enable,
        output duty_out,
        output fan_on,
        output hold_active
    );
endinterface

// File: rtl/fan_soft_start.sv
// Rate-limited fan duty ramp with a presence-loss hold-off.
// duty_out moves by at most one step per prescaler tick toward a registered goal.
module fan_soft_start #(
    parameter int STEP_CYC   = 1_000_000,
    parameter int HOLD_STEPS = 300
) (
    input  logic               clk,
    input  logic               reset_n,
    fan_soft_start_if.slave    bus
);

    localparam int         PS_W     = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
    localparam int         HC_W     = $clog2(HOLD_STEPS + 1);
    localparam logic [6:0] DUTY_MAX = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAMP,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [6:0]        goal_q, goal_d;
    logic [6:0]        duty_q, duty_d;
    logic              fan_on_q, fan_on_d;
    logic              hold_active_q, hold_active_d;
    logic              step_tick;
    logic              in_hold;
    logic              hold_d;
    logic [6:0]        target_clamped;

    // Free-running prescaler; inputs never disturb its phase.
    always_comb begin
        step_tick = (ps_q == PS_W'(STEP_CYC - 1));
        ps_d      = step_tick ? '0 : ps_q + PS_W'(1);
    end

    always_comb begin
        target_clamped = (bus.target_duty > DUTY_MAX) ? DUTY_MAX : bus.target_duty;
        in_hold        = (state_q == ST_HOLD);
    end

    // Goal and hold tracking
    always_comb begin
        goal_d     = goal_q;
        hold_cnt_d = hold_cnt_q;
        hold_d     = in_hold;

        if (!bus.enable) begin
            goal_d     = '0;
            hold_d     = 1'b0;
            hold_cnt_d = '0;
        end else if (bus.present) begin
            goal_d     = target_clamped;
            hold_d     = 1'b0;
            hold_cnt_d = '0;
        end else if (in_hold) begin
            // Goal stays frozen; only the tick count advances.
            if (step_tick) begin
                if (hold_cnt_q == HC_W'(HOLD_STEPS - 1)) begin
                    goal_d     = '0;
                    hold_d     = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
        end else if (goal_q != 7'd0) begin
            hold_d     = 1'b1;
            hold_cnt_d = '0;
        end else begin
            goal_d = '0;
        end
    end

    // Ramp uses the registered goal, so a tick coincident with a goal update
    // still steps toward the old goal.
    always_comb begin
        duty_d = duty_q;
        if (step_tick) begin
            if (duty_q < goal_q) begin
                duty_d = duty_q + 7'd1;
            end else if (duty_q > goal_q) begin
                duty_d = duty_q - 7'd1;
            end
        end
    end

    always_comb begin
        state_d = ST_RAMP;
        if (hold_d) begin
            state_d = ST_HOLD;
        end else if (duty_d == goal_d) begin
            state_d = (goal_d == 7'd0) ? ST_IDLE : ST_RUN;
        end
        fan_on_d      = (duty_d != 7'd0);
        hold_active_d = hold_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            ps_q          <= '0;
            hold_cnt_q    <= '0;
            goal_q        <= '0;
            duty_q        <= '0;
            fan_on_q      <= 1'b0;
            hold_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ps_q          <= ps_d;
            hold_cnt_q    <= hold_cnt_d;
            goal_q        <= goal_d;
            duty_q        <= duty_d;
            fan_on_q      <= fan_on_d;
            hold_active_q <= hold_active_d;
        end
    end

    assign bus.duty_out    = duty_q;
    assign bus.fan_on      = fan_on_q;
    assign bus.hold_active = hold_active_q;

endmodule

// File: tb/tb_fan_soft_start.sv
// Scoreboard bench for fan_soft_start: stimulus queues expected output changes,
// a negedge monitor pops and compares each observed change of the output tuple.
module tb_fan_soft_start;

    localparam int STEP_CYC   = 4;
    localparam int HOLD_STEPS = 5;
    localparam int DC_MAX     = 1000;

    typedef struct {
        int duty;
        bit fan;
        bit hold;
        int gmin;
        int gmax;
    } exp_t;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;
    int   cyc;
    int   last_cyc;
    int   prev_duty;
    bit   prev_fan;
    bit   prev_hold;
    exp_t exp_q[$];

    fan_soft_start_if bus_if();

    fan_soft_start #(
        .STEP_CYC   (STEP_CYC),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every change of (duty_out, fan_on, hold_active) is one transaction.
    initial begin
        prev_duty = 0;
        prev_fan  = 1'b0;
        prev_hold = 1'b0;
        last_cyc  = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_duty = int'(bus_if.duty_out);
                prev_fan  = bus_if.fan_on;
                prev_hold = bus_if.hold_active;
                last_cyc  = cyc;
            end else if (int'(bus_if.duty_out) != prev_duty || bus_if.fan_on != prev_fan
                         || bus_if.hold_active != prev_hold) begin
                int gap;
                gap = cyc - last_cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got duty=%0d fan=%0b hold=%0b, required no change",
                             bus_if.duty_out, bus_if.fan_on, bus_if.hold_active);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (int'(bus_if.duty_out) != e.duty || bus_if.fan_on != e.fan
                        || bus_if.hold_active != e.hold || gap < e.gmin || gap > e.gmax) begin
                        bad++;
                        $display("FAIL output_change: got duty=%0d fan=%0b hold=%0b gap=%0d, required duty=%0d fan=%0b hold=%0b gap=%0d..%0d",
                                 bus_if.duty_out, bus_if.fan_on, bus_if.hold_active, gap,
                                 e.duty, e.fan, e.hold, e.gmin, e.gmax);
                    end else begin
                        $display("change t=%0t duty=%0d fan=%0b hold=%0b gap=%0d ok",
                                 $time, bus_if.duty_out, bus_if.fan_on, bus_if.hold_active, gap);
                    end
                end
                prev_duty = int'(bus_if.duty_out);
                prev_fan  = bus_if.fan_on;
                prev_hold = bus_if.hold_active;
                last_cyc  = cyc;
            end
        end
    end

    task automatic push(input int d, input bit h, input int gmin, input int gmax);
        exp_t e;
        e.duty = d;
        e.fan  = (d != 0);
        e.hold = h;
        e.gmin = gmin;
        e.gmax = gmax;
        exp_q.push_back(e);
    endtask

    // Queue a ramp from 'from' to 'to'; first step phase is unknown, the rest are one tick apart.
    task automatic push_ramp(input int from, input int to);
        int v;
        bit first;
        v     = from;
        first = 1'b1;
        while (v != to) begin
            v = (to > from) ? v + 1 : v - 1;
            if (first) push(v, 1'b0, 0, DC_MAX);
            else       push(v, 1'b0, STEP_CYC, STEP_CYC);
            first = 1'b0;
        end
    endtask

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end else begin
            $display("check %s = %0d ok", nm, act);
        end
    endtask

    task automatic drive(input int t, input bit p, input bit e);
        @(posedge clk);
        #1;
        bus_if.target_duty = 7'(t);
        bus_if.present     = p;
        bus_if.enable      = e;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d pending changes, required 0", nm, exp_q.size());
            exp_q.delete();
        end else begin
            $display("phase %s complete", nm);
        end
        repeat (12) @(posedge clk);
    endtask

    // Release reset between edges and count cycles to the first duty step.
    task automatic release_and_time(input string nm);
        int n;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (bus_if.duty_out != 7'd0) break;
        end
        check(nm, n, STEP_CYC);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        bus_if.target_duty = 7'd0;
        bus_if.present     = 1'b0;
        bus_if.enable      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_duty", int'(bus_if.duty_out), 0);
        check("reset_fan_on", int'(bus_if.fan_on), 0);
        check("reset_hold", int'(bus_if.hold_active), 0);

        // 1. soft start to 3
        bus_if.target_duty = 7'd3;
        bus_if.present     = 1'b1;
        bus_if.enable      = 1'b1;
        push_ramp(0, 3);
        release_and_time("first_step_after_reset");
        wait_drain("soft_start");
        check("soft_start_final", int'(bus_if.duty_out), 3);

        // 2. clamp at 100, then down to 98, then back to 3
        push_ramp(3, 100);
        drive(120, 1'b1, 1'b1);
        wait_drain("clamp_up");
        check("clamp_final", int'(bus_if.duty_out), 100);
        push_ramp(100, 98);
        drive(98, 1'b1, 1'b1);
        wait_drain("down_98");
        push_ramp(98, 3);
        drive(3, 1'b1, 1'b1);
        wait_drain("down_3");

        // 3. presence loss: hold 5 ticks then ramp down
        push(3, 1'b1, 0, DC_MAX);
        push(3, 1'b0, 4 * STEP_CYC + 1, 5 * STEP_CYC);
        push(2, 1'b0, STEP_CYC, STEP_CYC);
        push(1, 1'b0, STEP_CYC, STEP_CYC);
        push(0, 1'b0, STEP_CYC, STEP_CYC);
        drive(3, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("hold_next_cycle", int'(bus_if.hold_active), 1);
        wait_drain("hold_rampdown");
        check("idle_fan_on", int'(bus_if.fan_on), 0);

        // 4. presence returns during hold with a new target
        push_ramp(0, 3);
        drive(3, 1'b1, 1'b1);
        wait_drain("restart_3");
        push(3, 1'b1, 0, DC_MAX);
        drive(3, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        push(3, 1'b0, 0, DC_MAX);
        push_ramp(3, 5);
        drive(5, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("hold_exit_next_cycle", int'(bus_if.hold_active), 0);
        wait_drain("presence_return");

        // 5. timer expiry without hold, then expiry during hold
        push_ramp(5, 3);
        drive(3, 1'b1, 1'b1);
        wait_drain("back_to_3");
        push_ramp(3, 0);
        drive(3, 1'b1, 1'b0);
        wait_drain("expiry_rampdown");
        push_ramp(0, 3);
        drive(3, 1'b1, 1'b1);
        wait_drain("restart_3b");
        push(3, 1'b1, 0, DC_MAX);
        drive(3, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        push(3, 1'b0, 0, DC_MAX);
        push_ramp(3, 0);
        drive(3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_abort_next_cycle", int'(bus_if.hold_active), 0);
        wait_drain("hold_abort");

        // 6. asynchronous reset mid-ramp at duty 2
        push_ramp(0, 2);
        drive(3, 1'b1, 1'b1);
        begin
            int n;
            n = 0;
            while (n < 40) begin
                @(negedge clk);
                #1;
                n++;
                if (bus_if.duty_out == 7'd2) break;
            end
            check("reached_duty_2", int'(bus_if.duty_out), 2);
        end
        #1;
        reset_n = 1'b0;
        #1;
        check("async_reset_duty", int'(bus_if.duty_out), 0);
        check("async_reset_fan_on", int'(bus_if.fan_on), 0);
        check("async_reset_hold", int'(bus_if.hold_active), 0);
        repeat (2) @(posedge clk);
        push_ramp(0, 3);
        release_and_time("first_step_after_rerelease");
        wait_drain("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
